// File: rtl/apb_timeout_guard_pkg.sv
// Shared types for the APB timeout guard: FSM state encoding and default abort read data.
package apb_timeout_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   localparam logic [15:0] ERR_RDATA_DEFAULT = 16'hDEAD;
   localparam int          APB_ADDR_W        = 24;

endpackage

// File: rtl/apb_timeout_guard_if.sv
// APB bus bundle used on both sides of the timeout guard.
// Handshake: a transfer is SETUP (psel=1, penable=0) then ACCESS (psel=1, penable=1) until pready=1 is sampled on clk.
interface apb_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 24
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  pclk;
   logic                  preset_n;
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [STRB_WIDTH-1:0] pstrb;
   logic [2:0]            pprot;
   logic                  pwakeup;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport requester (
      output pclk, preset_n, psel, penable, pwrite, paddr, pwdata, pstrb, pprot, pwakeup,
      input  prdata, pready, pslverr
   );

   modport completer (
      input  pclk, preset_n, psel, penable, pwrite, paddr, pwdata, pstrb, pprot, pwakeup,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/apb_timeout_guard_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; holds at all-ones instead of wrapping.
module apb_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/apb_timeout_guard.sv
// APB timeout guard: re-issues upstream transfers downstream and aborts any ACCESS phase that overstays TIMEOUT_CYCLES.
// Define APB_TIMEOUT_LOG_EN to build the err_count / err_addr timeout log; otherwise both ports read 0.
module apb_timeout_guard
   import apb_timeout_pkg::*;
#(
   parameter int                    TIMEOUT_CYCLES = 255,
   parameter int                    DATA_WIDTH     = 16,
   parameter logic [DATA_WIDTH-1:0] ERR_RDATA      = DATA_WIDTH'(ERR_RDATA_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   apb_if.completer              up,
   apb_if.requester              down,
   output logic                  timeout_pulse,
   output logic [15:0]           err_count,
   output logic [APB_ADDR_W-1:0] err_addr,
   output state_e                o_dbg_state
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int               STRB_W   = DATA_WIDTH / 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e                  r_state;
   state_e                  w_next;
   logic [CNT_W-1:0]        r_cnt;
   logic [APB_ADDR_W-1:0]   r_paddr;
   logic                    r_pwrite;
   logic [DATA_WIDTH-1:0]   r_pwdata;
   logic [STRB_W-1:0]       r_pstrb;
   logic [DATA_WIDTH-1:0]   r_prdata;
   logic                    r_pslverr;
   logic                    r_timeout_pulse;
   logic                    w_latch;
   logic                    w_done;
   logic                    w_timeout;
   logic                    w_resp;
   logic                    w_unused;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // pready is tested before the counter, so a completion on the last allowed cycle is never flagged.
   always_comb begin
      w_next    = r_state;
      w_latch   = 1'b0;
      w_done    = 1'b0;
      w_timeout = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (up.psel) begin
               w_latch = 1'b1;
               w_next  = ST_SETUP;
            end
         end
         ST_SETUP: w_next = ST_ACCESS;
         ST_ACCESS: begin
            if (down.pready) begin
               w_done = 1'b1;
               w_next = ST_RESP;
            end else if (r_cnt == CNT_LAST) begin
               w_timeout = 1'b1;
               w_next    = ST_RESP;
            end
         end
         ST_RESP: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt           <= '0;
         r_paddr         <= '0;
         r_pwrite        <= 1'b0;
         r_pwdata        <= '0;
         r_pstrb         <= '0;
         r_prdata        <= '0;
         r_pslverr       <= 1'b0;
         r_timeout_pulse <= 1'b0;
      end else begin
         r_timeout_pulse <= w_timeout;
         if (w_latch) begin
            r_paddr  <= up.paddr;
            r_pwrite <= up.pwrite;
            r_pwdata <= up.pwdata;
            r_pstrb  <= up.pstrb;
         end
         if (r_state == ST_ACCESS) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            r_cnt <= '0;
         end
         if (w_done) begin
            r_prdata  <= down.prdata;
            r_pslverr <= down.pslverr;
         end else if (w_timeout) begin
            r_prdata  <= ERR_RDATA;
            r_pslverr <= 1'b1;
         end
      end
   end

   assign down.pclk     = clk;
   assign down.preset_n = rst_n;
   assign down.psel     = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
   assign down.penable  = (r_state == ST_ACCESS);
   assign down.pwrite   = r_pwrite;
   assign down.paddr    = r_paddr;
   assign down.pwdata   = r_pwdata;
   assign down.pstrb    = r_pstrb;
   assign down.pprot    = 3'b000;
   assign down.pwakeup  = 1'b0;

   // An upstream that dropped psel gets no response; the captured data stays hidden.
   assign w_resp      = (r_state == ST_RESP) && up.psel;
   assign up.pready   = w_resp;
   assign up.prdata   = w_resp ? r_prdata : '0;
   assign up.pslverr  = w_resp & r_pslverr;

   assign timeout_pulse = r_timeout_pulse;
   assign o_dbg_state   = r_state;

`ifdef APB_TIMEOUT_LOG_EN
   logic [APB_ADDR_W-1:0] r_err_addr;

   apb_sat_counter #(
      .WIDTH (16)
   ) u_err_count (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_inc   (w_timeout),
      .o_count (err_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_addr <= '0;
      end else if (w_timeout) begin
         r_err_addr <= r_paddr;
      end
   end

   assign err_addr = r_err_addr;
`else
   assign err_count = '0;
   assign err_addr  = '0;
`endif

   assign w_unused = ^{up.pclk, up.preset_n, up.penable, up.pprot, up.pwakeup};

endmodule

// File: tb/tb_apb_timeout_guard.sv
// Directed plus randomized bench for apb_timeout_guard with a transaction-level reference model.
`timescale 1ns/1ps
module tb_apb_timeout_guard;
   import apb_timeout_pkg::*;

   localparam int              T       = 8;
   localparam int              DW      = 16;
   localparam int              NEVER   = 1000;
   localparam logic [DW-1:0]   ERR_VAL = 16'hDEAD;

   // clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   apb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(24)) up_if ();
   apb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(24)) down_if ();

   logic        timeout_pulse;
   logic [15:0] err_count;
   logic [23:0] err_addr;
   state_e      dbg_state;

   assign up_if.pclk     = clk;
   assign up_if.preset_n = rst_n;

   apb_timeout_guard #(
      .TIMEOUT_CYCLES (T),
      .DATA_WIDTH     (DW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .up            (up_if),
      .down          (down_if),
      .timeout_pulse (timeout_pulse),
      .err_count     (err_count),
      .err_addr      (err_addr),
      .o_dbg_state   (dbg_state)
   );

   int checks = 0;
   int errors = 0;

   // reference model: timeout log state
   logic [15:0] model_cnt  = '0;
   logic [23:0] model_addr = '0;

   function automatic logic [15:0] exp_count();
`ifdef APB_TIMEOUT_LOG_EN
      return model_cnt;
`else
      return 16'h0000;
`endif
   endfunction

   function automatic logic [23:0] exp_eaddr();
`ifdef APB_TIMEOUT_LOG_EN
      return model_addr;
`else
      return 24'h000000;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // downstream completer: pready on ACCESS cycle index comp_wait (0-based)
   int          comp_wait    = 0;
   logic [DW-1:0] comp_rdata = '0;
   logic        comp_slverr  = 1'b0;
   logic        stray_pready = 1'b0;
   int          acc_idx      = 0;

   always @(negedge clk) begin
      if (down_if.psel && down_if.penable) begin
         down_if.pready  = (acc_idx == comp_wait);
         down_if.prdata  = comp_rdata;
         down_if.pslverr = comp_slverr;
         acc_idx++;
      end else begin
         acc_idx         = 0;
         down_if.pready  = stray_pready;
         down_if.prdata  = stray_pready ? 16'h5A5A : 16'h0000;
         down_if.pslverr = stray_pready;
      end
   end

   // bus monitors
   int          pulse_cnt = 0, pready_cnt = 0, setup_cnt = 0, access_cnt = 0;
   int          attr_err = 0, idle_data_err = 0;
   logic [23:0] exp_paddr  = '0;
   logic        exp_pwrite = 1'b0;
   logic [15:0] exp_pwdata = '0;
   logic [1:0]  exp_pstrb  = '0;

   always @(negedge clk) begin
      if (timeout_pulse) pulse_cnt++;
      if (up_if.pready) pready_cnt++;
      if (down_if.psel && !down_if.penable) setup_cnt++;
      if (down_if.psel && down_if.penable) access_cnt++;
      if (down_if.psel && ((down_if.paddr !== exp_paddr) || (down_if.pwrite !== exp_pwrite) ||
                           (down_if.pwdata !== exp_pwdata) || (down_if.pstrb !== exp_pstrb)))
         attr_err++;
      if (!up_if.pready && ((up_if.prdata !== 16'h0000) || (up_if.pslverr !== 1'b0)))
         idle_data_err++;
   end

   // driver: one complete upstream transfer, checked against the model
   task automatic do_xfer(input string tag, input logic [23:0] addr, input logic wr,
                          input logic [15:0] wdata, input logic [1:0] strb, input int wait_c,
                          input logic [15:0] rdata, input logic slv, input logic stray,
                          input logic release_rst);
      int            edges;
      int            p0, r0, s0, a0, e0;
      int            exp_lat, exp_acc;
      logic          to;
      logic [15:0]   exp_rd;
      logic          exp_err;
      to      = (wait_c >= T);
      exp_lat = 3 + (to ? T - 1 : wait_c);
      exp_acc = to ? T : wait_c + 1;
      exp_rd  = to ? ERR_VAL : rdata;
      exp_err = to ? 1'b1 : slv;
      if (to) begin
         if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
         model_addr = addr;
      end
      comp_wait    = wait_c;
      comp_rdata   = rdata;
      comp_slverr  = slv;
      stray_pready = stray;
      exp_paddr    = addr;
      exp_pwrite   = wr;
      exp_pwdata   = wdata;
      exp_pstrb    = strb;
      p0 = pulse_cnt; r0 = pready_cnt; s0 = setup_cnt; a0 = access_cnt; e0 = attr_err;
      @(posedge clk); #2;
      if (release_rst) rst_n = 1'b1;
      up_if.psel    = 1'b1;
      up_if.penable = 1'b0;
      up_if.paddr   = addr;
      up_if.pwrite  = wr;
      up_if.pwdata  = wdata;
      up_if.pstrb   = strb;
      edges = 0;
      while (edges < 50) begin
         @(posedge clk); #1;
         edges++;
         if (edges == 1) up_if.penable = 1'b1;
         if (up_if.pready === 1'b1) break;
      end
      check({tag, ".latency"}, edges, exp_lat);
      check({tag, ".prdata"}, up_if.prdata, exp_rd);
      check({tag, ".pslverr"}, up_if.pslverr, exp_err);
      check({tag, ".timeout_pulse"}, timeout_pulse, to);
      check({tag, ".err_count"}, err_count, exp_count());
      check({tag, ".err_addr"}, err_addr, exp_eaddr());
      @(posedge clk); #2;
      up_if.psel    = 1'b0;
      up_if.penable = 1'b0;
      @(posedge clk); #1;
      check({tag, ".pulse_cycles"}, pulse_cnt - p0, to);
      check({tag, ".pready_cycles"}, pready_cnt - r0, 1);
      check({tag, ".setup_cycles"}, setup_cnt - s0, 1);
      check({tag, ".access_cycles"}, access_cnt - a0, exp_acc);
      check({tag, ".attr_hold"}, attr_err - e0, 0);
      check({tag, ".idle_prdata"}, up_if.prdata, 16'h0000);
      stray_pready = 1'b0;
   endtask

   int r0_main, a0_main, p0_main;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rnd;
      int          w;
      up_if.psel    = 1'b0;
      up_if.penable = 1'b0;
      up_if.pwrite  = 1'b0;
      up_if.paddr   = '0;
      up_if.pwdata  = '0;
      up_if.pstrb   = '0;
      up_if.pprot   = '0;
      up_if.pwakeup = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst.state", dbg_state, ST_IDLE);
      check("rst.down_psel", down_if.psel, 1'b0);
      check("rst.down_penable", down_if.penable, 1'b0);
      check("rst.up_pready", up_if.pready, 1'b0);
      check("rst.up_prdata", up_if.prdata, 16'h0000);
      check("rst.timeout_pulse", timeout_pulse, 1'b0);
      check("rst.err_count", err_count, 16'h0000);
      check("rst.err_addr", err_addr, 24'h000000);
      check("rst.preset_n", down_if.preset_n, 1'b0);
      check("rst.pprot", down_if.pprot, 3'b000);

      // directed cases; first transfer issued on the edge right after reset release
      do_xfer("rd_zero_wait", 24'h000010, 1'b0, 16'h0000, 2'b00, 0, 16'h1234, 1'b0, 1'b0, 1'b1);
      check("preset_follow", down_if.preset_n, 1'b1);
      do_xfer("wr_beef", 24'h000022, 1'b1, 16'hBEEF, 2'b01, 2, 16'h0000, 1'b0, 1'b0, 1'b0);
      do_xfer("timeout_never", 24'hABCDE0, 1'b0, 16'h0000, 2'b00, NEVER, 16'h7777, 1'b0, 1'b0, 1'b0);
      do_xfer("pready_last_cycle", 24'h000044, 1'b0, 16'h0000, 2'b00, T - 1, 16'h4321, 1'b1, 1'b0, 1'b0);
      do_xfer("pready_one_late", 24'h123456, 1'b1, 16'h0F0F, 2'b11, T, 16'h9999, 1'b0, 1'b0, 1'b0);
      do_xfer("stray_pready", 24'h000066, 1'b0, 16'h0000, 2'b10, 3, 16'hCAFE, 1'b0, 1'b1, 1'b0);

      // upstream abandons during ACCESS: no response upstream
      r0_main = pready_cnt; a0_main = access_cnt; p0_main = pulse_cnt;
      comp_wait = 5; comp_rdata = 16'h1111; comp_slverr = 1'b0;
      exp_paddr = 24'h000088; exp_pwrite = 1'b0; exp_pwdata = '0; exp_pstrb = '0;
      @(posedge clk); #2;
      up_if.psel = 1'b1; up_if.penable = 1'b0; up_if.paddr = 24'h000088;
      up_if.pwrite = 1'b0; up_if.pwdata = '0; up_if.pstrb = '0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (i == 0) up_if.penable = 1'b1;
      end
      #1;
      up_if.psel = 1'b0; up_if.penable = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("abandon.pready_cycles", pready_cnt - r0_main, 0);
      check("abandon.access_cycles", access_cnt - a0_main, 6);
      check("abandon.pulse_cycles", pulse_cnt - p0_main, 0);
      check("abandon.state", dbg_state, ST_IDLE);

      // asynchronous reset in the middle of ACCESS
      r0_main = pready_cnt;
      comp_wait = NEVER;
      exp_paddr = 24'h000333;
      @(posedge clk); #2;
      up_if.psel = 1'b1; up_if.penable = 1'b0; up_if.paddr = 24'h000333;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (i == 0) up_if.penable = 1'b1;
      end
      check("pre_rst.in_access", down_if.penable, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      model_cnt = '0;
      model_addr = '0;
      check("midrst.down_psel", down_if.psel, 1'b0);
      check("midrst.down_penable", down_if.penable, 1'b0);
      check("midrst.down_paddr", down_if.paddr, 24'h000000);
      check("midrst.up_pready", up_if.pready, 1'b0);
      check("midrst.timeout_pulse", timeout_pulse, 1'b0);
      check("midrst.err_count", err_count, exp_count());
      check("midrst.err_addr", err_addr, exp_eaddr());
      check("midrst.state", dbg_state, ST_IDLE);
      check("midrst.preset_n", down_if.preset_n, 1'b0);
      up_if.psel = 1'b0; up_if.penable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("midrst.no_response", pready_cnt - r0_main, 0);
      do_xfer("post_rst_read", 24'h000010, 1'b0, 16'h0000, 2'b00, 0, 16'h2468, 1'b0, 1'b0, 1'b1);

      // randomized traffic against the model
      for (int n = 0; n < 40; n++) begin
         rnd = $urandom;
         w = $urandom_range(0, T + 2);
         if (w == T + 2) w = NEVER;
         do_xfer($sformatf("rand%0d", n), rnd[23:0], 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 16'hFFFF)), 2'($urandom_range(0, 3)), w,
                 16'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0);
      end

      check("prdata_zero_outside_resp", idle_data_err, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
